// File: rtl/adc_serial_capture_pkg.sv
// Shared constants and FSM encoding for the serial ADC capture front-end.
// The SDFT consumes samples of the same DATA_W width.
package adc_serial_capture_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int DATA_W_DEF     = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_QUIET   = 2'd2
    } cap_state_e;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_serial_capture_sclk_gen.sv
// Serial clock generator: toggles SCLK every CLK_DIV clocks while run_i is high,
// idles high otherwise, and flags each rising edge and the last one of a frame.
module adc_sclk_gen
    import adc_serial_capture_pkg::*;
#(
    parameter int CLK_DIV    = 5,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic last_rise_o
);

    localparam int HC_W = cnt_w(CLK_DIV);
    localparam int RC_W = cnt_w(FRAME_BITS);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(FRAME_BITS - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            sclk_q, sclk_d;
    logic            toggle;

    assign toggle      = run_i && (hc_q == HC_LAST);
    assign rise_o      = toggle && !sclk_q;
    assign last_rise_o = rise_o && (rc_q == RC_LAST);
    assign sclk_o      = sclk_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        hc_d   = hc_q;
        rc_d   = rc_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            hc_d   = '0;
            rc_d   = '0;
            sclk_d = 1'b1;
        end else if (toggle) begin
            hc_d   = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) rc_d = rc_q + 1'b1;
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q   <= '0;
            rc_q   <= '0;
            sclk_q <= 1'b1;
        end else begin
            hc_q   <= hc_d;
            rc_q   <= rc_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_serial_capture.sv
// ADCS7476-style serial capture: frames CS/SCLK at a fixed sample rate, deserialises
// the data pin and offers each result on a valid/ready handshake with sticky overrun.
module adc_serial_capture
    import adc_serial_capture_pkg::*;
#(
    parameter int CLK_DIV       = 5,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int FRAME_BITS    = FRAME_BITS_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int QUIET_CLKS    = 10,
    parameter bit SIGNED_OUT    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              adc_mic_cs,
    output logic              adc_mic_clk,
    input  logic              adc_mic_sd,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int PER_W = cnt_w(SAMPLE_PERIOD);
    localparam int Q_W   = cnt_w(QUIET_CLKS);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CLKS - 1);

    cap_state_e        state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [Q_W-1:0]    quiet_q, quiet_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              cs_q, cs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              rise, last_rise, load;
    logic [DATA_W-1:0] conv;

    adc_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_sclk (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_i       (state_q == ST_CONVERT),
        .sclk_o      (adc_mic_clk),
        .rise_o      (rise),
        .last_rise_o (last_rise)
    );

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        quiet_d = quiet_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cs_d    = 1'b1;
                quiet_d = '0;
                if (enable && (per_q == '0)) begin
                    state_d = ST_CONVERT;
                    cs_d    = 1'b0;
                end
            end
            ST_CONVERT: begin
                if (last_rise) begin
                    state_d = ST_QUIET;
                    cs_d    = 1'b1;
                end
            end
            ST_QUIET: begin
                if (quiet_q == Q_LAST) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
            end
        endcase
    end

    // Only the last DATA_W bits are kept; the leading zeros fall off the top unchecked.
    always_comb begin
        per_d   = (state_q == ST_IDLE && !enable) ? '0 :
                  (per_q == PER_LAST)             ? '0 : per_q + 1'b1;
        shift_d = rise ? {shift_q[DATA_W-2:0], adc_mic_sd} : shift_q;
        conv    = shift_q;
        if (SIGNED_OUT) conv[DATA_W-1] = ~shift_q[DATA_W-1];
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = conv;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) ovr_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            quiet_q <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            quiet_q <= quiet_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_mic_cs   = cs_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: ADC pin model, frame-level reference model with a
// per-cycle compare process, plus literal checks on timing and conversion values.
module tb_adc_serial_capture;

    localparam int CLK_DIV  = 5;
    localparam int SP       = 2500;
    localparam int FB       = 16;
    localparam int QC       = 10;
    localparam int LOW_CLKS = 2 * CLK_DIV * FB;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, sd = 1'b0, ready = 1'b1;
    logic cs_s, sclk_s, valid_s, ovr_s, cs_u, sclk_u, valid_u, ovr_u;
    logic [11:0] data_s, data_u;
    int errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_serial_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .FRAME_BITS(FB),
        .DATA_W(12), .QUIET_CLKS(QC), .SIGNED_OUT(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .adc_mic_cs(cs_s),
        .adc_mic_clk(sclk_s), .adc_mic_sd(sd), .sample_data(data_s),
        .sample_valid(valid_s), .sample_ready(ready), .overrun(ovr_s));

    adc_serial_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .FRAME_BITS(FB),
        .DATA_W(12), .QUIET_CLKS(QC), .SIGNED_OUT(1'b0)) dut_u (
        .clk(clk), .reset_n(reset_n), .enable(enable), .adc_mic_cs(cs_u),
        .adc_mic_clk(sclk_u), .adc_mic_sd(sd), .sample_data(data_u),
        .sample_valid(valid_u), .sample_ready(ready), .overrun(ovr_u));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame timeline counted in clock edges since CS fall.
    logic [15:0] word_q[$];
    logic [15:0] m_word = 16'h0;
    bit          m_active = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
    int          m_k = 0, m_ph = 0;
    logic [11:0] m_ds = 12'h0, m_du = 12'h0;

    initial forever begin : model
        bit idle_before, load;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_active = 1'b0; m_k = 0; m_ph = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_ds = 12'h0; m_du = 12'h0;
        end else begin
            idle_before = !m_active;
            load = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == LOW_CLKS + QC) begin
                    load = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (idle_before && enable && m_ph == 0) begin
                m_active = 1'b1;
                m_k = 0;
                m_word = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
            end
            m_ph = (idle_before && !enable) ? 0 : (m_ph + 1) % SP;
            if (load) begin
                if (m_valid && !ready) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_du = m_word[11:0];
                m_ds = m_word[11:0] ^ 12'h800;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ADC pin model: drives the next bit MSB-first on every SCLK fall while CS is low.
    initial begin : adc_pin
        int fidx;
        fidx = FB - 1;
        forever begin
            @(negedge sclk_s or posedge cs_s);
            if (cs_s) fidx = FB - 1;
            else if (!sclk_s && fidx >= 0) begin
                sd = m_word[fidx];
                fidx--;
            end
        end
    end

    initial forever begin : compare
        logic e_cs, e_sclk;
        @(negedge clk);
        e_cs   = !(m_active && m_k < LOW_CLKS);
        e_sclk = e_cs ? 1'b1 : (((m_k / CLK_DIV) % 2) == 0);
        check("cs", cs_s, e_cs);
        check("cs_u", cs_u, e_cs);
        check("sclk", sclk_s, e_sclk);
        check("sclk_u", sclk_u, e_sclk);
        check("valid", valid_s, m_valid);
        check("valid_u", valid_u, m_valid);
        check("data_signed", data_s, m_ds);
        check("data_unsigned", data_u, m_du);
        check("overrun", ovr_s, m_ovr);
        check("overrun_u", ovr_u, m_ovr);
    end

    task automatic wait_cs_fall(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!cs_s) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid_s) begin ok = 1'b1; break; end
        end
    endtask

    initial begin : stim
        bit ok;
        int t0, low, nr, falls;
        int rises[$];
        logic prev;
        logic [11:0] lit_u [3];
        logic [11:0] lit_s [3];
        lit_u = '{12'h000, 12'h800, 12'hFFF};
        lit_s = '{12'h800, 12'h000, 12'h7FF};
        word_q = '{16'h0ABC, 16'h0000, 16'h0800, 16'h0FFF, 16'h0123, 16'h0F0E, 16'hF5A5};

        repeat (3) @(negedge clk);
        check("reset_cs", cs_s, 1'b1);
        check("reset_sclk", sclk_s, 1'b1);
        check("reset_valid", valid_s, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        // First frame: CS width, SCLK spacing, latency, value and period.
        wait_cs_fall(10, ok);
        check("first_cs_fall_seen", ok, 1'b1);
        t0 = cyc; low = 1; prev = sclk_s;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sclk_s && !prev) rises.push_back(cyc);
            prev = sclk_s;
            if (cs_s) break;
            low++;
        end
        check("cs_low_clocks", low, LOW_CLKS);
        check("sclk_rise_count", rises.size(), FB);
        if (rises.size() > 0) check("first_rise_offset", rises[0] - t0, 2 * CLK_DIV);
        for (int i = 1; i < rises.size(); i++)
            check("sclk_rise_spacing", rises[i] - rises[i-1], 2 * CLK_DIV);
        wait_valid(40, ok);
        check("first_valid_seen", ok, 1'b1);
        if (rises.size() > 0) check("valid_latency", cyc - rises[rises.size()-1], QC);
        check("first_sample_signed", data_s, 12'h2BC);
        check("first_sample_unsigned", data_u, 12'hABC);
        @(negedge clk);
        check("valid_one_cycle", valid_s, 1'b0);
        wait_cs_fall(3000, ok);
        check("second_cs_fall_seen", ok, 1'b1);
        check("sample_period", cyc - t0, SP);

        // Conversion boundaries: zero, midscale, full scale.
        for (int i = 0; i < 3; i++) begin
            wait_valid(3000, ok);
            check("boundary_valid_seen", ok, 1'b1);
            check("boundary_unsigned", data_u, lit_u[i]);
            check("boundary_signed", data_s, lit_s[i]);
            @(negedge clk);
        end

        // Overrun: hold ready low across two loads.
        ready = 1'b0;
        wait_valid(3000, ok);
        check("ovr_first_valid_seen", ok, 1'b1);
        check("ovr_first_data", data_s, 12'h923);
        check("ovr_not_yet", ovr_s, 1'b0);
        repeat (SP - 1) @(negedge clk);
        check("ovr_held_data", data_s, 12'h923);
        check("ovr_held_valid", valid_s, 1'b1);
        @(negedge clk);
        check("ovr_new_data", data_s, 12'h70E);
        check("ovr_valid", valid_s, 1'b1);
        check("ovr_set", ovr_s, 1'b1);
        ready = 1'b1;
        @(negedge clk);
        check("ovr_consumed", valid_s, 1'b0);
        check("ovr_sticky", ovr_s, 1'b1);

        // Random backpressure over several frames.
        for (int i = 0; i < 4 * SP; i++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ready = 1'b1;

        // Drop enable at bit 5: the frame completes, then no more frames.
        word_q.delete();
        word_q.push_back(16'h0A5F);
        wait_cs_fall(3000, ok);
        check("drop_cs_fall_seen", ok, 1'b1);
        nr = 0; prev = sclk_s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sclk_s && !prev) nr++;
            prev = sclk_s;
            if (nr == 5) break;
        end
        enable = 1'b0;
        wait_valid(400, ok);
        check("drop_valid_seen", ok, 1'b1);
        check("drop_sample_signed", data_s, 12'h25F);
        check("drop_sample_unsigned", data_u, 12'hA5F);
        falls = 0; prev = cs_s;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (prev && !cs_s) falls++;
            prev = cs_s;
        end
        check("no_frames_while_disabled", falls, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_starts_frame", cs_s, 1'b0);

        // Asynchronous reset mid-CONVERT, while SCLK is low and overrun is set.
        repeat (27) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_cs", cs_s, 1'b1);
        check("async_rst_sclk", sclk_s, 1'b1);
        check("async_rst_valid", valid_s, 1'b0);
        check("async_rst_overrun", ovr_s, 1'b0);
        check("async_rst_data", data_s, 12'h000);
        repeat (3) @(negedge clk);
        word_q.delete();
        word_q.push_back(16'h0C3A);
        reset_n = 1'b1;
        wait_cs_fall(5, ok);
        check("post_reset_cs_fall_seen", ok, 1'b1);
        wait_valid(300, ok);
        check("post_reset_valid_seen", ok, 1'b1);
        check("post_reset_signed", data_s, 12'h43A);
        check("post_reset_unsigned", data_u, 12'hC3A);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
